ps2_kbd_ascii: RTL
==================

Name: ps2_kbd_ascii

Overview:
PS/2 keyboard front-end. It receives device-to-host PS/2 frames and tracks modifier state. It translates set-2 make codes to ASCII and queues the characters. It is the producer side of the system's ascii keyboard interface (kbd_int / kbd_data / kbd_int_ack), and that interface is consumed by phy_mem_ctrl.

Parameters:
TIMEOUT_CYCLES, 5000, clk cycles without a PS/2 falling edge mid-frame before the frame is aborted (100 us at 50 MHz)
FIFO_DEPTH, 4, character queue depth; must be a power of two and at least 2

Ports:
clk  in  1  system clock, the 50 MHz domain
rst  in  1  asynchronous reset, active-low
ps2_clk  in  1  raw PS/2 clock from the pad, asynchronous to clk
ps2_data  in  1  raw PS/2 data from the pad, asynchronous to clk
kbd_int  out  1  character available; level signal
kbd_data  out  8  ASCII code at the head of the queue; valid while kbd_int=1
kbd_int_ack  in  1  consumer acknowledge; a pop occurs on its rising edge
frame_err  out  1  one-cycle pulse on a start, stop or parity error, or on a timeout
overflow  out  1  one-cycle pulse when a character is dropped because the queue is full

Behaviour:
- Reset state (rst=0, asynchronous): kbd_int=0, kbd_data=0x00, frame_err=0, overflow=0. Queue empty, all modifiers cleared, receiver and decoder idle.
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is sync_clk[1]=1 followed by sync_clk[0]=0. Data is sampled on the same cycle as the edge.
- Receiver FSM (IDLE, SHIFT):
  - IDLE: on a falling edge with data=0 (start bit), go to SHIFT and set bitcnt=0. A falling edge with data=1 is ignored.
  - SHIFT: capture 8 data bits LSB first, then parity, then stop. After the 10th capture, check odd parity (data bits plus parity bit has an odd count of 1s) and stop=1.
  - Good frame: a 1-cycle byte_valid strobe to the decoder. Bad frame: a frame_err pulse and the byte is discarded. Either way, return to IDLE.
  - Watchdog: a counter resets on every falling edge and runs while in SHIFT. When it reaches TIMEOUT_CYCLES, pulse frame_err and return to IDLE.
- Decoder FSM (NORMAL, BREAK, EXT, EXT_BREAK), advancing one state per byte_valid:
  - NORMAL: F0 goes to BREAK. E0 goes to EXT. 12 or 59 sets the matching shift flag. 58 toggles caps. Any other code is a make and is translated.
  - BREAK: 12 or 59 clears the matching shift flag; any other code is ignored. Then go to NORMAL.
  - EXT: F0 goes to EXT_BREAK; any other code is ignored and returns to NORMAL.
  - EXT_BREAK: any code is ignored; return to NORMAL. Extended keys (including the fake shifts E0 12) therefore never alter state and never emit a character.
  - Byte AA (BAT ok) and FA (ack) in NORMAL are ignored.
- Translation, handled by a combinational ROM:
  - Letters: lowercase; uppercase when shift XOR caps.
  - Digit row and punctuation: shifted forms (US layout) when shift=1; caps has no effect.
  - Named keys: 29 space gives 0x20, 5A Enter gives 0x0A, 66 Backspace gives 0x08, 0D Tab gives 0x09, 76 Esc gives 0x1B.
  - An unmapped code emits nothing.
  - shift = lshift OR rshift.
- Queue: circular FIFO of FIFO_DEPTH entries with pointers one bit wider than the index.
  - A push attempted while full drops the character and pulses overflow; contents are unchanged.
  - A push and a pop on the same cycle are both performed (including when full).
- Consumer handshake:
  - kbd_int = registered (not empty AND not gap). kbd_data is the registered head entry.
  - A pop occurs on a kbd_int_ack rising edge (ack=1, ack_d=0) while kbd_int=1. An ack held high for several cycles pops once; an ack while empty is ignored.
  - After each pop: kbd_int=0 for exactly one cycle (gap), then re-asserts with the new head if the queue is non-empty.
  - Latency from the stop-bit falling edge of a make frame to kbd_int=1 is at most 4 clk cycles.
- A frame straddling reset is lost; after reset the receiver resynchronizes on the next start bit.

Decomposition:
- ps2_kbd_pkg holds:
  - the scancode constants: F0, E0, 12, 59, 58, AA and FA
  - the receiver and decoder state encodings
  - the ASCII constants for the named keys
- One sub-module, kbd_scancode_rom: purely combinational; inputs {code[7:0], shift, caps}; outputs {ascii[7:0], valid}.
- The FIFO stays inline.

Test Plan:
- Frame 1C (odd parity bit 0), no ack -> kbd_int=1, kbd_data=0x61; single ack pulse -> kbd_int=0 for 1 cycle, then stays 0.
- Frames 12, 16, F0 16, F0 12, 16 -> queue 0x21 then 0x31; pops in order with a 1-cycle gap between them.
- Frames 58, 1C, 58, 1C -> 0x41 then 0x61; frames E0 75 and E0 F0 75 -> no char, no frame_err.
- Frame 1C with a wrong parity bit -> frame_err pulse, kbd_int stays 0; frame with stop=0 -> frame_err pulse.
- 5 bits sent then ps2_clk held high for 6000 cycles -> frame_err at cycle 5000 of idle; the following frame 32 -> kbd_data=0x62.
- 5 make codes 1C 32 21 23 24 with no ack -> overflow pulses once; pops return 61 62 63 64; after the 4th pop kbd_int stays 0. Asserting rst=0 mid-frame clears all outputs immediately.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard front-end: set-2 scancodes,
// FSM state encodings and ASCII values of the named keys.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;

    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_SHIFT = 1'b1;

    localparam logic [1:0] DEC_NORMAL    = 2'd0;
    localparam logic [1:0] DEC_BREAK     = 2'd1;
    localparam logic [1:0] DEC_EXT       = 2'd2;
    localparam logic [1:0] DEC_EXT_BREAK = 2'd3;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_ESC   = 8'h1B;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kbd_scancode_rom.sv
// Combinational set-2 make code to ASCII translation (US layout).
// Letters follow shift XOR caps; digits and punctuation follow shift only.
module kbd_scancode_rom
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic [7:0] o_ascii,
    output logic       o_valid
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic       w_letter;

    always_comb begin
        w_lo = 8'h00;
        w_hi = 8'h00;
        case (i_code)
            8'h1C: w_lo = "a";
            8'h32: w_lo = "b";
            8'h21: w_lo = "c";
            8'h23: w_lo = "d";
            8'h24: w_lo = "e";
            8'h2B: w_lo = "f";
            8'h34: w_lo = "g";
            8'h33: w_lo = "h";
            8'h43: w_lo = "i";
            8'h3B: w_lo = "j";
            8'h42: w_lo = "k";
            8'h4B: w_lo = "l";
            8'h3A: w_lo = "m";
            8'h31: w_lo = "n";
            8'h44: w_lo = "o";
            8'h4D: w_lo = "p";
            8'h15: w_lo = "q";
            8'h2D: w_lo = "r";
            8'h1B: w_lo = "s";
            8'h2C: w_lo = "t";
            8'h3C: w_lo = "u";
            8'h2A: w_lo = "v";
            8'h1D: w_lo = "w";
            8'h22: w_lo = "x";
            8'h35: w_lo = "y";
            8'h1A: w_lo = "z";
            8'h16: begin w_lo = "1"; w_hi = "!"; end
            8'h1E: begin w_lo = "2"; w_hi = "@"; end
            8'h26: begin w_lo = "3"; w_hi = "#"; end
            8'h25: begin w_lo = "4"; w_hi = "$"; end
            8'h2E: begin w_lo = "5"; w_hi = "%"; end
            8'h36: begin w_lo = "6"; w_hi = "^"; end
            8'h3D: begin w_lo = "7"; w_hi = "&"; end
            8'h3E: begin w_lo = "8"; w_hi = "*"; end
            8'h46: begin w_lo = "9"; w_hi = "("; end
            8'h45: begin w_lo = "0"; w_hi = ")"; end
            8'h0E: begin w_lo = 8'h60; w_hi = 8'h7E; end
            8'h4E: begin w_lo = "-"; w_hi = "_"; end
            8'h55: begin w_lo = "="; w_hi = "+"; end
            8'h54: begin w_lo = "["; w_hi = "{"; end
            8'h5B: begin w_lo = "]"; w_hi = "}"; end
            8'h5D: begin w_lo = 8'h5C; w_hi = "|"; end
            8'h4C: begin w_lo = ";"; w_hi = ":"; end
            8'h52: begin w_lo = "'"; w_hi = 8'h22; end
            8'h41: begin w_lo = ","; w_hi = "<"; end
            8'h49: begin w_lo = "."; w_hi = ">"; end
            8'h4A: begin w_lo = "/"; w_hi = "?"; end
            8'h29: begin w_lo = ASC_SPACE; w_hi = ASC_SPACE; end
            8'h5A: begin w_lo = ASC_LF;    w_hi = ASC_LF;    end
            8'h66: begin w_lo = ASC_BS;    w_hi = ASC_BS;    end
            8'h0D: begin w_lo = ASC_TAB;   w_hi = ASC_TAB;   end
            8'h76: begin w_lo = ASC_ESC;   w_hi = ASC_ESC;   end
            default: begin w_lo = 8'h00; w_hi = 8'h00; end
        endcase
    end

    // Only letters land in 'a'..'z'; a zero entry marks an unmapped code.
    assign w_letter = (w_lo >= 8'h61) && (w_lo <= 8'h7A);
    assign o_valid  = (w_lo != 8'h00);
    assign o_ascii  = w_letter ? ((i_shift ^ i_caps) ? (w_lo - 8'h20) : w_lo)
                               : (i_shift ? w_hi : w_lo);

endmodule

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver, modifier-tracking decoder and ASCII character
// queue feeding the kbd_int / kbd_data / kbd_int_ack consumer interface.
module ps2_kbd_ascii
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_int,
    output logic [7:0] kbd_data,
    input  logic       kbd_int_ack,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          w_fall;
    logic          w_bit;

    logic [0:0]    r_rx_state;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_byte;
    logic          r_par;
    logic [TW-1:0] r_wdog;
    logic          r_byte_valid;
    logic          r_frame_err;
    logic          w_timeout;

    logic [1:0]    r_dec_state;
    logic          r_lshift;
    logic          r_rshift;
    logic          r_caps;
    logic [7:0]    w_ascii;
    logic          w_rom_valid;
    logic          w_special;
    logic          w_push;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_ack_d;
    logic          r_kbd_int;
    logic [7:0]    r_kbd_data;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    // Clock sync resets low so a pad held low across reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 2'b00;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_fall    = r_clk_sync[1] & ~r_clk_sync[0];
    assign w_bit     = r_dat_sync[0];
    assign w_timeout = (r_rx_state == RX_SHIFT) && !w_fall &&
                       (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state   <= RX_IDLE;
            r_bitcnt     <= 4'd0;
            r_byte       <= 8'h00;
            r_par        <= 1'b0;
            r_wdog       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall || (r_rx_state == RX_IDLE)) r_wdog <= '0;
            else                                   r_wdog <= r_wdog + 1'b1;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_fall && !w_bit) begin
                        r_rx_state <= RX_SHIFT;
                        r_bitcnt   <= 4'd0;
                    end
                end
                RX_SHIFT: begin
                    if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= RX_IDLE;
                    end else if (w_fall) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt < 4'd8) begin
                            r_byte <= {w_bit, r_byte[7:1]};
                        end else if (r_bitcnt == 4'd8) begin
                            r_par <= w_bit;
                        end else begin
                            r_rx_state <= RX_IDLE;
                            if (w_bit && odd_parity_ok(r_byte, r_par)) r_byte_valid <= 1'b1;
                            else                                       r_frame_err  <= 1'b1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    kbd_scancode_rom u_rom (
        .i_code  (r_byte),
        .i_shift (r_lshift | r_rshift),
        .i_caps  (r_caps),
        .o_ascii (w_ascii),
        .o_valid (w_rom_valid)
    );

    assign w_special = r_byte inside {SC_BREAK, SC_EXT, SC_LSHIFT, SC_RSHIFT,
                                      SC_CAPS, SC_BAT_OK, SC_ACK};
    assign w_push    = r_byte_valid && (r_dec_state == DEC_NORMAL) &&
                       !w_special && w_rom_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec_state <= DEC_NORMAL;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
        end else if (r_byte_valid) begin
            case (r_dec_state)
                DEC_NORMAL: begin
                    if (r_byte == SC_BREAK)       r_dec_state <= DEC_BREAK;
                    else if (r_byte == SC_EXT)    r_dec_state <= DEC_EXT;
                    else if (r_byte == SC_LSHIFT) r_lshift    <= 1'b1;
                    else if (r_byte == SC_RSHIFT) r_rshift    <= 1'b1;
                    else if (r_byte == SC_CAPS)   r_caps      <= ~r_caps;
                end
                DEC_BREAK: begin
                    if (r_byte == SC_LSHIFT)      r_lshift <= 1'b0;
                    else if (r_byte == SC_RSHIFT) r_rshift <= 1'b0;
                    r_dec_state <= DEC_NORMAL;
                end
                DEC_EXT: begin
                    r_dec_state <= (r_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
                end
                default: r_dec_state <= DEC_NORMAL;
            endcase
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = kbd_int_ack && !r_ack_d && r_kbd_int;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_ascii;
    end

    // Clearing kbd_int on the pop cycle produces the one-cycle gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ack_d    <= 1'b0;
            r_kbd_int  <= 1'b0;
            r_kbd_data <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_ack_d    <= kbd_int_ack;
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_kbd_int <= !w_empty && !w_pop;
            if (!w_empty) r_kbd_data <= r_mem[r_rptr[AW-1:0]];
        end
    end

    assign kbd_int   = r_kbd_int;
    assign kbd_data  = r_kbd_data;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
